// File: rtl/mc_ctrl.sv
`default_nettype none
// ============================================================================
// mc_ctrl : multi-cycle IF/ID/EX/MEM/WB control FSM for the MIPS datapath
// Rev 1.0
// ============================================================================
module mc_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       imem_ready,
  input  logic       dmem_ready,
  output logic       imem_re,
  output logic       dmem_re,
  output logic       dmem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] npc_sel,
  output logic       reg_we,
  output logic [1:0] regdst,
  output logic [1:0] wdsel,
  output logic       alusrc,
  output logic       extop,
  output logic [1:0] aluop,
  output logic       instr_done,
  output logic       err
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4,
    S_ERR = 3'd7
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;

  logic is_r, is_addu, is_subu, is_jr, is_nop;
  logic is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_illegal;
  logic timed_out;

  assign is_r       = (opcode == 6'b000000);
  assign is_addu    = is_r && (funct == 6'b100001);
  assign is_subu    = is_r && (funct == 6'b100011);
  assign is_jr      = is_r && (funct == 6'b001000);
  assign is_nop     = is_r && (funct == 6'b000000);
  assign is_ori     = (opcode == 6'b001101);
  assign is_lui     = (opcode == 6'b001111);
  assign is_lw      = (opcode == 6'b100011);
  assign is_sw      = (opcode == 6'b101011);
  assign is_beq     = (opcode == 6'b000100);
  assign is_j       = (opcode == 6'b000010);
  assign is_jal     = (opcode == 6'b000011);
  assign is_illegal = !(is_addu || is_subu || is_jr || is_nop || is_ori || is_lui ||
                        is_lw || is_sw || is_beq || is_j || is_jal);
  assign timed_out  = (cnt == C_LAST);

  // Next state and state-gated enables; a ready in the last allowed cycle beats the timeout.
  always_comb begin
    state_nxt  = state;
    imem_re    = 1'b0;
    dmem_re    = 1'b0;
    dmem_we    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    reg_we     = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_IF: begin
        imem_re = 1'b1;
        if (imem_ready) begin
          ir_we     = 1'b1;
          pc_we     = 1'b1;
          state_nxt = S_ID;
        end else if (timed_out) begin
          state_nxt = S_ERR;
        end
      end
      S_ID: begin
        if (is_illegal) begin
          state_nxt = S_ERR;
        end else if (is_nop || is_j || is_jal || is_jr) begin
          pc_we      = !is_nop;
          reg_we     = is_jal;
          instr_done = 1'b1;
          state_nxt  = S_IF;
        end else begin
          state_nxt = S_EX;
        end
      end
      S_EX: begin
        if (is_beq) begin
          pc_we      = zero;
          instr_done = 1'b1;
          state_nxt  = S_IF;
        end else if (is_lw || is_sw) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        dmem_re = is_lw;
        dmem_we = !is_lw;
        if (dmem_ready) begin
          instr_done = !is_lw;
          state_nxt  = is_lw ? S_WB : S_IF;
        end else if (timed_out) begin
          state_nxt = S_ERR;
        end
      end
      S_WB: begin
        reg_we     = 1'b1;
        instr_done = 1'b1;
        state_nxt  = S_IF;
      end
      S_ERR:   state_nxt = S_ERR;
      default: state_nxt = S_IF;
    endcase
    if (reset) begin
      imem_re    = 1'b0;
      dmem_re    = 1'b0;
      dmem_we    = 1'b0;
      ir_we      = 1'b0;
      pc_we      = 1'b0;
      reg_we     = 1'b0;
      instr_done = 1'b0;
    end
  end

  // Datapath selects follow the held IR; only the fetch cycle forces the PC+4 path.
  always_comb begin
    npc_sel = 2'd0;
    if (state != S_IF) begin
      if (is_beq)             npc_sel = 2'd1;
      else if (is_j || is_jal) npc_sel = 2'd2;
      else if (is_jr)         npc_sel = 2'd3;
    end
    regdst = is_jal ? 2'd2 : (is_r ? 2'd1 : 2'd0);
    wdsel  = is_jal ? 2'd2 : (is_lw ? 2'd1 : 2'd0);
    alusrc = is_ori || is_lui || is_lw || is_sw;
    extop  = is_lw || is_sw || is_beq;
    if (is_subu || is_beq) aluop = 2'd1;
    else if (is_ori)       aluop = 2'd2;
    else if (is_lui)       aluop = 2'd3;
    else                   aluop = 2'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IF;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)
        cnt <= '0;
      else if (state == S_IF || state == S_MEM)
        cnt <= cnt + 1'b1;
      if (state_nxt == S_ERR)
        err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mc_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mc_ctrl : randomized + directed bench for mc_ctrl against a per-instruction cycle model
// Rev 1.0
// ============================================================================
module tb_mc_ctrl;
  localparam int TIMEOUT = 16;
  localparam int K_RADD = 0, K_RSUB = 1, K_JR = 2, K_NOP = 3, K_ORI = 4, K_LUI = 5;
  localparam int K_LW = 6, K_SW = 7, K_BEQ = 8, K_J = 9, K_JAL = 10, K_ILL = 11;

  logic clk = 1'b0, reset = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic zero = 1'b0, imem_ready = 1'b0, dmem_ready = 1'b0;
  logic imem_re, dmem_re, dmem_we, ir_we, pc_we, reg_we, alusrc, extop, instr_done, err;
  logic [1:0] npc_sel, regdst, wdsel, aluop;

  mc_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_re(imem_re), .dmem_re(dmem_re),
    .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we), .npc_sel(npc_sel), .reg_we(reg_we),
    .regdst(regdst), .wdsel(wdsel), .alusrc(alusrc), .extop(extop), .aluop(aluop),
    .instr_done(instr_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic imem_re, dmem_re, dmem_we, ir_we, pc_we, reg_we, done, err;
    logic [1:0] npc, rdst, wds;
    logic dchk, asrc; logic [1:0] aop;
    logic echk, ext;
  } exp_t;

  int n_chk = 0, n_fail = 0;
  exp_t exp_r;
  bit chk_en = 0;
  logic req = 1'b0;
  int req_kind = 0, pin_cpi = 0, pin_dre = 0;
  string tag = "idle";
  int cyc_cnt = 0, dre_cnt = 0, last_cpi = -1, last_dre = -1;

  function automatic exp_t zexp();
    exp_t e;
    e.imem_re = 0; e.dmem_re = 0; e.dmem_we = 0; e.ir_we = 0; e.pc_we = 0; e.reg_we = 0;
    e.done = 0; e.err = 0; e.npc = 0; e.rdst = 0; e.wds = 0;
    e.dchk = 0; e.asrc = 0; e.aop = 0; e.echk = 0; e.ext = 0;
    return e;
  endfunction

  function automatic bit rb();
    return ($urandom & 1) != 0;
  endfunction

  function automatic int cls(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'h00: case (fn)
               6'h21: return K_RADD;
               6'h23: return K_RSUB;
               6'h08: return K_JR;
               6'h00: return K_NOP;
               default: return K_ILL;
             endcase
      6'h0d: return K_ORI;
      6'h0f: return K_LUI;
      6'h23: return K_LW;
      6'h2b: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  task automatic check_cycle();
    logic [7:0] a, x;
    bit ok;
    a = {imem_re, dmem_re, dmem_we, ir_we, pc_we, reg_we, instr_done, err};
    x = {exp_r.imem_re, exp_r.dmem_re, exp_r.dmem_we, exp_r.ir_we, exp_r.pc_we, exp_r.reg_we,
         exp_r.done, exp_r.err};
    ok = (a === x);
    if (exp_r.pc_we && npc_sel !== exp_r.npc) ok = 0;
    if (exp_r.reg_we && (regdst !== exp_r.rdst || wdsel !== exp_r.wds)) ok = 0;
    if (exp_r.dchk && (alusrc !== exp_r.asrc || aluop !== exp_r.aop)) ok = 0;
    if (exp_r.echk && extop !== exp_r.ext) ok = 0;
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s t=%0t: got en=%b npc=%0d rdst=%0d wds=%0d asrc=%b aop=%0d ext=%b, expected en=%b npc=%0d rdst=%0d wds=%0d asrc=%b aop=%0d ext=%b",
               tag, $time, a, npc_sel, regdst, wdsel, alusrc, aluop, extop,
               x, exp_r.npc, exp_r.rdst, exp_r.wds, exp_r.asrc, exp_r.aop, exp_r.ext);
    end
  endtask

  // Single compare process: per-cycle checks at negedge, plus on-request probes.
  initial forever begin
    @(negedge clk or posedge req);
    if (req) begin
      if (req_kind == 0) begin
        check_cycle();
      end else begin
        n_chk++;
        if (last_cpi != pin_cpi || (pin_dre >= 0 && last_dre != pin_dre)) begin
          n_fail++;
          $display("FAIL %s: got cpi=%0d dre_cycles=%0d, expected cpi=%0d dre_cycles=%0d",
                   tag, last_cpi, last_dre, pin_cpi, pin_dre);
        end
      end
    end else if (chk_en) begin
      check_cycle();
      if (reset) begin
        cyc_cnt = 0; dre_cnt = 0;
      end else begin
        cyc_cnt++;
        if (dmem_re) dre_cnt++;
        if (instr_done) begin
          last_cpi = cyc_cnt; last_dre = dre_cnt; cyc_cnt = 0; dre_cnt = 0;
        end
      end
    end
  end

  task automatic fire(input int kind);
    req_kind = kind; req = 1'b1; #1; req = 1'b0;
  endtask

  task automatic cyc(input exp_t e, input logic ir, input logic dr, input logic z);
    imem_ready = ir; dmem_ready = dr; zero = z; exp_r = e; chk_en = 1;
    @(posedge clk); #1;
  endtask

  task automatic pin(input string t, input int cpi, input int dre);
    tag = t; pin_cpi = cpi; pin_dre = dre; fire(1);
  endtask

  // Enables must vanish as soon as reset rises, then stay low while it is held.
  task automatic do_reset(input int n);
    reset = 1'b1; #1;
    tag = "reset_gate"; exp_r = zexp(); fire(0);
    tag = "in_reset";
    repeat (n) cyc(zexp(), rb(), rb(), rb());
    reset = 1'b0;
  endtask

  task automatic err_cycles(input exp_t b);
    exp_t e;
    e = b; e.err = 1;
    repeat (3) cyc(e, rb(), rb(), rb());
  endtask

  // Expands one instruction into its expected cycle sequence (ddly<0: abort after one MEM cycle).
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int idly,
                           input int ddly, input logic z, input string t, output bit errd);
    int k;
    exp_t b, e;
    k = cls(op, fn);
    errd = 0; tag = t; opcode = op; funct = fn;
    b = zexp();
    case (k)
      K_RADD: begin b.dchk = 1; b.asrc = 0; b.aop = 0; end
      K_RSUB: begin b.dchk = 1; b.asrc = 0; b.aop = 1; end
      K_ORI:  begin b.dchk = 1; b.asrc = 1; b.aop = 2; b.echk = 1; b.ext = 0; end
      K_LUI:  begin b.dchk = 1; b.asrc = 1; b.aop = 3; end
      K_LW, K_SW: begin b.dchk = 1; b.asrc = 1; b.aop = 0; b.echk = 1; b.ext = 1; end
      K_BEQ:  begin b.dchk = 1; b.asrc = 0; b.aop = 1; b.echk = 1; b.ext = 1; end
      default: ;
    endcase
    e = b; e.imem_re = 1;
    if (idly >= TIMEOUT) begin
      repeat (TIMEOUT) cyc(e, 0, rb(), rb());
      err_cycles(b); errd = 1; return;
    end
    repeat (idly) cyc(e, 0, rb(), rb());
    e.ir_we = 1; e.pc_we = 1; e.npc = 0;
    cyc(e, 1, rb(), rb());
    e = b;
    case (k)
      K_NOP: begin e.done = 1; cyc(e, rb(), rb(), rb()); return; end
      K_J:   begin e.pc_we = 1; e.npc = 2; e.done = 1; cyc(e, rb(), rb(), rb()); return; end
      K_JAL: begin
        e.pc_we = 1; e.npc = 2; e.reg_we = 1; e.rdst = 2; e.wds = 2; e.done = 1;
        cyc(e, rb(), rb(), rb()); return;
      end
      K_JR:  begin e.pc_we = 1; e.npc = 3; e.done = 1; cyc(e, rb(), rb(), rb()); return; end
      K_ILL: begin cyc(e, rb(), rb(), rb()); err_cycles(b); errd = 1; return; end
      default: cyc(e, rb(), rb(), rb());
    endcase
    e = b;
    if (k == K_BEQ) begin
      e.pc_we = z; e.npc = 1; e.done = 1;
      cyc(e, rb(), rb(), z); return;
    end
    cyc(e, rb(), rb(), rb());
    if (k == K_LW || k == K_SW) begin
      e = b;
      if (k == K_LW) e.dmem_re = 1; else e.dmem_we = 1;
      if (ddly < 0) begin cyc(e, rb(), 0, rb()); return; end
      if (ddly >= TIMEOUT) begin
        repeat (TIMEOUT) cyc(e, rb(), 0, rb());
        err_cycles(b); errd = 1; return;
      end
      repeat (ddly) cyc(e, rb(), 0, rb());
      if (k == K_SW) begin e.done = 1; cyc(e, rb(), 1, rb()); return; end
      cyc(e, rb(), 1, rb());
    end
    e = b; e.reg_we = 1; e.done = 1;
    e.rdst = (k == K_RADD || k == K_RSUB) ? 2'd1 : 2'd0;
    e.wds  = (k == K_LW) ? 2'd1 : 2'd0;
    cyc(e, rb(), rb(), rb());
  endtask

  logic [5:0] l_op [11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};
  logic [5:0] l_fn [11] = '{6'h21, 6'h23, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  initial begin
    bit errd;
    int r, idly, ddly;
    logic [5:0] op, fn;
    do_reset(2);
    run_instr(6'h0d, 6'h00, 0, 0, 0, "ori", errd);  pin("ori_cpi", 4, -1);
    run_instr(6'h23, 6'h00, 0, 3, 0, "lw_wait3", errd); pin("lw_wait3_cpi", 8, 4);
    run_instr(6'h04, 6'h00, 0, 0, 1, "beq_taken", errd); pin("beq_taken_cpi", 3, -1);
    run_instr(6'h04, 6'h00, 0, 0, 0, "beq_not", errd);   pin("beq_not_cpi", 3, -1);
    run_instr(6'h03, 6'h00, 0, 0, 0, "jal", errd);  pin("jal_cpi", 2, -1);
    run_instr(6'h00, 6'h21, 0, 0, 0, "addu", errd); pin("addu_cpi", 4, -1);
    run_instr(6'h00, 6'h23, 1, 0, 0, "subu", errd); pin("subu_cpi", 5, -1);
    run_instr(6'h0f, 6'h00, 0, 0, 0, "lui", errd);  pin("lui_cpi", 4, -1);
    run_instr(6'h2b, 6'h00, 0, 0, 0, "sw", errd);   pin("sw_cpi", 4, -1);
    run_instr(6'h23, 6'h00, 0, 0, 0, "lw", errd);   pin("lw_cpi", 5, 1);
    run_instr(6'h00, 6'h00, 0, 0, 0, "nop", errd);  pin("nop_cpi", 2, -1);
    run_instr(6'h00, 6'h08, 0, 0, 0, "jr", errd);   pin("jr_cpi", 2, -1);
    run_instr(6'h02, 6'h00, 0, 0, 0, "j", errd);    pin("j_cpi", 2, -1);
    run_instr(6'h3f, 6'h00, 0, 0, 0, "illegal", errd); do_reset(2);
    run_instr(6'h0d, 6'h00, TIMEOUT, 0, 0, "if_timeout", errd); do_reset(1);
    run_instr(6'h0d, 6'h00, TIMEOUT - 1, 0, 0, "if_ready_last", errd); pin("if_ready_last_cpi", 19, -1);
    run_instr(6'h23, 6'h00, 0, TIMEOUT, 0, "mem_timeout", errd); do_reset(1);
    run_instr(6'h2b, 6'h00, 0, TIMEOUT - 1, 0, "sw_ready_last", errd); pin("sw_ready_last_cpi", 19, -1);
    run_instr(6'h2b, 6'h00, 0, -1, 0, "sw_abort", errd); do_reset(2);
    run_instr(6'h0d, 6'h00, 0, 0, 0, "after_abort", errd); pin("after_abort_cpi", 4, -1);
    for (int i = 0; i < 80; i++) begin
      r = int'($urandom_range(13, 0));
      if (r < 11) begin op = l_op[r]; fn = l_fn[r]; end
      else if (r == 11) begin op = 6'h3f; fn = 6'($urandom); end
      else if (r == 12) begin op = 6'h00; fn = 6'($urandom); end
      else begin op = 6'($urandom); fn = 6'($urandom); end
      idly = ($urandom_range(24, 0) == 0) ? TIMEOUT - int'($urandom_range(1, 0)) : int'($urandom_range(3, 0));
      ddly = ($urandom_range(24, 0) == 0) ? TIMEOUT - int'($urandom_range(1, 0)) : int'($urandom_range(3, 0));
      run_instr(op, fn, idly, ddly, rb(), "random", errd);
      if (errd) do_reset(int'($urandom_range(2, 1)));
    end
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
